// File: rtl/instability_detect.sv
// Sweeps a reference-current setting upward and watches the measured quality for a sharp drop.
// When it sees one, it backs off to the last stable setting and stays there until reset.
module instability_detect #(
  parameter int WIDTH      = 10,
  parameter int DELTA      = 50,
  parameter int IREF_DELTA = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ready,
  input  logic             enable,
  input  logic [WIDTH-1:0] q_measured,
  output logic [WIDTH-1:0] i_ref_setup
);

  typedef enum logic [2:0] {IDLE, SAMPLE, COMPARE, FOUND, DONE} state_t;

  localparam logic [WIDTH:0]   STEP_W  = (WIDTH+1)'(IREF_DELTA);
  localparam logic [WIDTH:0]   DELTA_W = (WIDTH+1)'(DELTA);
  localparam logic [WIDTH:0]   MAX_W   = {1'b0, {WIDTH{1'b1}}};
  localparam logic [WIDTH-1:0] STEP_N  = WIDTH'(IREF_DELTA);

  state_t           state;
  logic             found;
  logic             first;
  logic [WIDTH-1:0] curr_q;
  logic [WIDTH-1:0] last_q;

  logic [WIDTH:0]   next_ref;
  logic             overflow;
  logic             dropped;
  logic [WIDTH-1:0] drop;
  logic             unstable;
  logic [WIDTH-1:0] back_ref;

  // The step is computed one bit wider so a sweep past full scale is caught.
  always_comb begin
    next_ref = {1'b0, i_ref_setup} + STEP_W;
    overflow = next_ref > MAX_W;
  end

  // Subtraction is only taken when last_q > curr_q, so it cannot wrap.
  always_comb begin
    dropped  = last_q > curr_q;
    drop     = dropped ? (last_q - curr_q) : '0;
    unstable = !first && dropped && ({1'b0, drop} > DELTA_W);
    back_ref = ({1'b0, i_ref_setup} >= STEP_W) ? (i_ref_setup - STEP_N) : '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      i_ref_setup <= '0;
      curr_q      <= '0;
      last_q      <= '0;
      found       <= 1'b0;
      first       <= 1'b1;
    end else begin
      case (state)
        IDLE: if (enable) state <= SAMPLE;
        SAMPLE: begin
          if (enable && ready) begin
            last_q <= curr_q;
            curr_q <= q_measured;
            state  <= COMPARE;
          end
        end
        COMPARE: begin
          if (enable) begin
            if (!found && unstable) begin
              found       <= 1'b1;
              i_ref_setup <= back_ref;
              state       <= FOUND;
            end else if (overflow) begin
              state <= DONE;
            end else begin
              i_ref_setup <= next_ref[WIDTH-1:0];
              first       <= 1'b0;
              state       <= SAMPLE;
            end
          end
        end
        FOUND:   state <= FOUND;
        DONE:    state <= DONE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instability_detect.sv
// Directed bench: table of environment shapes with hand-derived end states, plus timing, pause and reset sequences.
module tb_instability_detect;
  localparam int WIDTH = 10;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             ready = 1'b0;
  logic             enable = 1'b0;
  logic [WIDTH-1:0] q_measured;
  logic [WIDTH-1:0] i_ref_setup;
  int               mode = 0;
  int               n_chk = 0;
  int               n_fail = 0;

  instability_detect #(.WIDTH(WIDTH), .DELTA(50), .IREF_DELTA(10)) dut (
    .clk(clk), .rst(rst), .ready(ready), .enable(enable),
    .q_measured(q_measured), .i_ref_setup(i_ref_setup)
  );

  always #5 clk = ~clk;

  function automatic int q_model(input int m, input int r);
    case (m)
      0: return r;
      1: return (r < 200) ? r : 100;
      2: return (r < 200) ? r : 140;
      3: return (r < 200) ? r : 139;
      4: return 500;
      5: return 1023 - r;
      6: return (r == 0) ? 1000 : 0;
      7: return (r < 1020) ? r : 0;
      default: return 0;
    endcase
  endfunction

  always_comb q_measured = WIDTH'(q_model(mode, int'(i_ref_setup)));

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    enable = 1'b0;
    ready  = 1'b0;
    rst    = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  typedef struct {
    int mode;
    int exp_ref;
    int exp_found;
    int exp_curr;
    int exp_last;
  } vec_t;

  vec_t vecs[8];

  initial begin
    vecs[0] = '{0, 1020, 0, 1020, 1010};  // monotonic, stops at top
    vecs[1] = '{1,  190, 1,  100,  190};  // drop of 90
    vecs[2] = '{2, 1020, 0,  140,  140};  // drop of exactly 50
    vecs[3] = '{3,  190, 1,  139,  190};  // drop of 51
    vecs[4] = '{4, 1020, 0,  500,  500};  // flat
    vecs[5] = '{5, 1020, 0,    3,   13};  // small drops every step
    vecs[6] = '{6,    0, 1,    0, 1000};  // drop right after first sample
    vecs[7] = '{7, 1010, 1,    0, 1010};  // drop at the last step

    // Reset state, and nothing moves while enable is low
    mode = 0;
    do_reset();
    chk("rst_ref", int'(i_ref_setup), 0);
    chk("rst_found", int'(dut.found), 0);
    chk("rst_curr", int'(dut.curr_q), 0);
    chk("rst_last", int'(dut.last_q), 0);
    ready = 1'b1;
    repeat (5) @(negedge clk);
    chk("idle_ref", int'(i_ref_setup), 0);
    chk("idle_curr", int'(dut.curr_q), 0);

    // One step every two clocks after the IDLE->SAMPLE edge
    enable = 1'b1;
    repeat (3) @(negedge clk);
    chk("step1_ref", int'(i_ref_setup), 10);
    repeat (2) @(negedge clk);
    chk("step2_ref", int'(i_ref_setup), 20);
    chk("step2_curr", int'(dut.curr_q), 10);
    chk("step2_last", int'(dut.last_q), 0);
    repeat (2) @(negedge clk);
    chk("step3_ref", int'(i_ref_setup), 30);

    // Pause in SAMPLE
    enable = 1'b0;
    repeat (5) @(negedge clk);
    chk("pause_ref", int'(i_ref_setup), 30);
    chk("pause_curr", int'(dut.curr_q), 20);
    chk("pause_last", int'(dut.last_q), 10);
    enable = 1'b1;
    repeat (2) @(negedge clk);
    chk("resume_ref", int'(i_ref_setup), 40);
    chk("resume_curr", int'(dut.curr_q), 30);
    chk("resume_last", int'(dut.last_q), 20);

    // ready low holds the sweep in SAMPLE
    ready = 1'b0;
    repeat (6) @(negedge clk);
    chk("nordy_ref", int'(i_ref_setup), 40);
    chk("nordy_curr", int'(dut.curr_q), 30);
    ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("rdy_ref", int'(i_ref_setup), 50);
    chk("rdy_curr", int'(dut.curr_q), 40);

    // Pause in COMPARE
    @(negedge clk);
    enable = 1'b0;
    repeat (4) @(negedge clk);
    chk("pause_cmp_ref", int'(i_ref_setup), 50);
    enable = 1'b1;
    @(negedge clk);
    chk("resume_cmp_ref", int'(i_ref_setup), 60);

    // Asynchronous reset mid-sweep, then restart from zero
    #2 rst = 1'b1;
    #1;
    chk("async_rst_ref", int'(i_ref_setup), 0);
    chk("async_rst_curr", int'(dut.curr_q), 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("restart_ref", int'(i_ref_setup), 10);

    // Table: full sweeps against various environment shapes
    for (int i = 0; i < 8; i++) begin
      mode = vecs[i].mode;
      do_reset();
      enable = 1'b1;
      ready  = 1'b1;
      repeat (240) @(negedge clk);
      chk($sformatf("m%0d_ref", mode), int'(i_ref_setup), vecs[i].exp_ref);
      chk($sformatf("m%0d_found", mode), int'(dut.found), vecs[i].exp_found);
      chk($sformatf("m%0d_curr", mode), int'(dut.curr_q), vecs[i].exp_curr);
      chk($sformatf("m%0d_last", mode), int'(dut.last_q), vecs[i].exp_last);
      // Terminal states ignore enable/ready
      for (int k = 0; k < 10; k++) begin
        enable = k[0];
        ready  = k[1];
        @(negedge clk);
      end
      chk($sformatf("m%0d_hold_ref", mode), int'(i_ref_setup), vecs[i].exp_ref);
      chk($sformatf("m%0d_hold_found", mode), int'(dut.found), vecs[i].exp_found);
      #2 rst = 1'b1;
      #1;
      chk($sformatf("m%0d_rst_ref", mode), int'(i_ref_setup), 0);
      chk($sformatf("m%0d_rst_found", mode), int'(dut.found), 0);
      @(negedge clk);
      rst = 1'b0;
    end

    // After a reset out of FOUND, the sweep starts again cleanly
    mode   = 1;
    enable = 1'b1;
    ready  = 1'b1;
    repeat (5) @(negedge clk);
    chk("post_found_ref", int'(i_ref_setup), 20);
    chk("post_found_flag", int'(dut.found), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
